// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - data-memory load/store unit with valid/ack memory handshake
module dmem_lsu #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_re,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [2:0]    cpu_funct3,
    output logic          cpu_stall,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_fault,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_be;
    logic [1:0]    r_addr_lo;
    logic [2:0]    r_funct3;
    logic [31:0]   r_cpu_rdata;
    logic          r_cpu_fault;

    logic          w_access;
    logic          w_legal;
    logic          w_aligned;
    logic          w_valid;
    logic          w_bad;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load_fmt;
    logic          w_capture;
    logic          w_fault_set;
    logic          w_complete;
    logic          w_stall;

    // Decode the raw MEM-stage request: legality, alignment, lane enables, replicated store data
    always_comb begin
        w_access  = cpu_re | cpu_we;
        w_legal   = 1'b0;
        w_aligned = 1'b1;
        w_be      = 4'b1111;
        w_wdata   = cpu_wdata;
        // a store wins when both strobes are high, so it also decides legality
        if (cpu_we) begin
            w_legal = (cpu_funct3 == 3'b000) || (cpu_funct3 == 3'b001) || (cpu_funct3 == 3'b010);
        end else begin
            w_legal = (cpu_funct3 == 3'b000) || (cpu_funct3 == 3'b001) || (cpu_funct3 == 3'b010) ||
                      (cpu_funct3 == 3'b100) || (cpu_funct3 == 3'b101);
        end
        case (cpu_funct3[1:0])
            2'b01:   w_aligned = (cpu_addr[0] == 1'b0);
            2'b10:   w_aligned = (cpu_addr[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
        if (cpu_we) begin
            case (cpu_funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << cpu_addr[1:0];
                    w_wdata = {4{cpu_wdata[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << {cpu_addr[1], 1'b0};
                    w_wdata = {2{cpu_wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = cpu_wdata;
                end
            endcase
        end
        w_valid = w_access & w_legal & w_aligned;
        w_bad   = w_access & ~(w_legal & w_aligned);
    end

    // Extract the addressed lane from the returned word and extend it
    always_comb begin
        case (r_addr_lo)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_fmt = {24'd0, w_byte};
            3'b101:  w_load_fmt = {16'd0, w_half};
            default: w_load_fmt = mem_rdata;
        endcase
    end

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and the combinational stall / capture / completion strobes
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_capture   = 1'b0;
        w_fault_set = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_valid) begin
                    w_stall     = 1'b1;
                    w_capture   = 1'b1;
                    w_state_nxt = S_REQ;
                end else if (w_bad) begin
                    w_fault_set = 1'b1;
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (mem_ack) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // pipeline advances at the end of this cycle; the held request is not reissued
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Transaction registers, load-data register and the one-cycle fault pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_mem_be    <= 4'd0;
            r_addr_lo   <= 2'd0;
            r_funct3    <= 3'd0;
            r_cpu_rdata <= 32'd0;
            r_cpu_fault <= 1'b0;
        end else begin
            r_cpu_fault <= w_fault_set;
            if (w_capture) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= cpu_we;
                r_mem_addr  <= {cpu_addr[AW-1:2], 2'b00};
                r_mem_wdata <= w_wdata;
                r_mem_be    <= w_be;
                r_addr_lo   <= cpu_addr[1:0];
                r_funct3    <= cpu_funct3;
            end else if (w_complete) begin
                r_mem_req <= 1'b0;
            end
            if (w_complete && !r_mem_we) begin
                r_cpu_rdata <= w_load_fmt;
            end else if (w_fault_set) begin
                r_cpu_rdata <= 32'd0;
            end
        end
    end

    assign cpu_stall = w_stall;
    assign cpu_rdata = r_cpu_rdata;
    assign cpu_fault = r_cpu_fault;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_re;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_funct3;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        cpu_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_last;

    always #5 clk = ~clk;

    dmem_lsu #(.AW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_re     (cpu_re),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_funct3 (cpu_funct3),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_fault  (cpu_fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        int          delay;
        logic [31:0] rdata;
        logic        fault;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        int          e_stall;
        int          e_req;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  stall_n;
        int  req_n;
        bit  done;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        cpu_re     = v.re;
        cpu_we     = v.we;
        cpu_addr   = v.addr;
        cpu_wdata  = v.wdata;
        cpu_funct3 = v.f3;
        mem_ack    = 1'b0;
        stall_n    = 0;
        req_n      = 0;
        done       = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (mem_req) begin
                req_n++;
                if (req_n == 1) begin
                    chk({tag, " mem_we"}, {31'd0, mem_we}, {31'd0, v.we});
                    chk({tag, " mem_addr"}, mem_addr, v.e_addr);
                    chk({tag, " mem_be"}, {28'd0, mem_be}, {28'd0, v.e_be});
                    if (v.we) chk({tag, " mem_wdata"}, mem_wdata, v.e_wdata);
                end
                if (req_n == v.delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 32'h5A5A5A5A;
                end
            end else begin
                mem_ack = 1'b0;
            end
            if (cpu_stall) stall_n++;
            else done = 1;
            if (!done) @(negedge clk);
        end
        if (!done) begin
            chk({tag, " timeout"}, 32'd1, 32'd0);
            return;
        end
        if (v.fault) begin
            chk({tag, " fault stall"}, stall_n, 32'd0);
            chk({tag, " fault req"}, {31'd0, mem_req}, 32'd0);
            @(negedge clk);
            cpu_re = 1'b0;
            cpu_we = 1'b0;
            #1;
            chk({tag, " fault pulse"}, {31'd0, cpu_fault}, 32'd1);
            chk({tag, " fault rdata"}, cpu_rdata, 32'd0);
            chk({tag, " fault no req"}, {31'd0, mem_req}, 32'd0);
            exp_last = 32'd0;
            @(negedge clk);
            #1;
            chk({tag, " fault clears"}, {31'd0, cpu_fault}, 32'd0);
        end else begin
            if (v.re && !v.we) exp_last = v.e_rdata;
            chk({tag, " stall cycles"}, stall_n, v.e_stall);
            chk({tag, " req cycles"}, req_n, v.e_req);
            chk({tag, " done req low"}, {31'd0, mem_req}, 32'd0);
            chk({tag, " cpu_rdata"}, cpu_rdata, exp_last);
            chk({tag, " no fault"}, {31'd0, cpu_fault}, 32'd0);
        end
    endtask

    initial begin
        vec_t rv;
        reset      = 1'b1;
        cpu_re     = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = 32'd0;
        cpu_wdata  = 32'd0;
        cpu_funct3 = 3'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
        exp_last   = 32'd0;

        //        re  we  addr    wdata         f3  dly rdata         flt e_addr  be     e_wdata       e_rdata       st rq
        vecs[0]  = '{1, 0, 32'h40, 32'h0,        3'b010, 3, 32'hDEADBEEF, 0, 32'h40, 4'hF, 32'h0,        32'hDEADBEEF, 4, 3};
        vecs[1]  = '{1, 0, 32'h43, 32'h0,        3'b000, 1, 32'h80FF0000, 0, 32'h40, 4'hF, 32'h0,        32'hFFFFFF80, 2, 1};
        vecs[2]  = '{1, 0, 32'h43, 32'h0,        3'b100, 1, 32'h80FF0000, 0, 32'h40, 4'hF, 32'h0,        32'h00000080, 2, 1};
        vecs[3]  = '{1, 0, 32'h42, 32'h0,        3'b001, 1, 32'h80FF0000, 0, 32'h40, 4'hF, 32'h0,        32'hFFFF80FF, 2, 1};
        vecs[4]  = '{1, 0, 32'h42, 32'h0,        3'b101, 1, 32'h80FF1234, 0, 32'h40, 4'hF, 32'h0,        32'h000080FF, 2, 1};
        vecs[5]  = '{1, 0, 32'h40, 32'h0,        3'b001, 1, 32'h80FF1234, 0, 32'h40, 4'hF, 32'h0,        32'h00001234, 2, 1};
        vecs[6]  = '{1, 0, 32'h41, 32'h0,        3'b000, 2, 32'h80FF1234, 0, 32'h40, 4'hF, 32'h0,        32'h00000012, 3, 2};
        vecs[7]  = '{0, 1, 32'h45, 32'h123456AB, 3'b000, 2, 32'h0,        0, 32'h44, 4'h2, 32'hABABABAB, 32'h0,        3, 2};
        vecs[8]  = '{0, 1, 32'h46, 32'h123456AB, 3'b001, 1, 32'h0,        0, 32'h44, 4'hC, 32'h56AB56AB, 32'h0,        2, 1};
        vecs[9]  = '{0, 1, 32'h48, 32'hCAFEF00D, 3'b010, 1, 32'h0,        0, 32'h48, 4'hF, 32'hCAFEF00D, 32'h0,        2, 1};
        vecs[10] = '{1, 0, 32'h48, 32'h0,        3'b010, 1, 32'h0BADF00D, 0, 32'h48, 4'hF, 32'h0,        32'h0BADF00D, 2, 1};
        vecs[11] = '{1, 1, 32'h40, 32'h000000C3, 3'b000, 1, 32'h0,        0, 32'h40, 4'h1, 32'hC3C3C3C3, 32'h0,        2, 1};
        vecs[12] = '{1, 0, 32'h41, 32'h0,        3'b010, 0, 32'h0,        1, 32'h0,  4'h0, 32'h0,        32'h0,        0, 0};
        vecs[13] = '{0, 1, 32'h43, 32'h0,        3'b001, 0, 32'h0,        1, 32'h0,  4'h0, 32'h0,        32'h0,        0, 0};
        vecs[14] = '{1, 0, 32'h40, 32'h0,        3'b011, 0, 32'h0,        1, 32'h0,  4'h0, 32'h0,        32'h0,        0, 0};
        vecs[15] = '{0, 1, 32'h40, 32'h0,        3'b100, 0, 32'h0,        1, 32'h0,  4'h0, 32'h0,        32'h0,        0, 0};
        vecs[16] = '{1, 0, 32'h40, 32'h0,        3'b110, 0, 32'h0,        1, 32'h0,  4'h0, 32'h0,        32'h0,        0, 0};
        vecs[17] = '{0, 1, 32'h47, 32'h000000EE, 3'b000, 1, 32'h0,        0, 32'h44, 4'h8, 32'hEEEEEEEE, 32'h0,        2, 1};
        vecs[18] = '{1, 0, 32'h47, 32'h0,        3'b100, 5, 32'hEE000000, 0, 32'h44, 4'hF, 32'h0,        32'h000000EE, 6, 5};

        repeat (2) @(negedge clk);
        #1;
        chk("reset mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset mem_be", {28'd0, mem_be}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        chk("reset cpu_rdata", cpu_rdata, 32'd0);
        chk("reset cpu_fault", {31'd0, cpu_fault}, 32'd0);
        chk("reset cpu_stall", {31'd0, cpu_stall}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) run_vec(i, vecs[i]);

        // reset while waiting for ack abandons the transaction at once
        @(negedge clk);
        cpu_re     = 1'b1;
        cpu_we     = 1'b0;
        cpu_addr   = 32'h40;
        cpu_funct3 = 3'b010;
        mem_ack    = 1'b0;
        @(negedge clk);
        #1;
        chk("rst pre mem_req", {31'd0, mem_req}, 32'd1);
        #2;
        reset  = 1'b1;
        cpu_re = 1'b0;
        #1;
        chk("rst async mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst async stall", {31'd0, cpu_stall}, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h11111111;
        @(negedge clk);
        #1;
        chk("late ack mem_req", {31'd0, mem_req}, 32'd0);
        chk("late ack rdata", cpu_rdata, 32'd0);
        chk("late ack stall", {31'd0, cpu_stall}, 32'd0);
        mem_ack  = 1'b0;
        exp_last = 32'd0;
        rv = '{1, 0, 32'h40, 32'h0, 3'b010, 2, 32'h76543210, 0, 32'h40, 4'hF, 32'h0, 32'h76543210, 3, 2};
        run_vec(100, rv);

        @(negedge clk);
        cpu_re = 1'b0;
        cpu_we = 1'b0;
        #1;
        chk("idle no reissue", {31'd0, mem_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
